// File: rtl/cfg_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cfg_write_arbiter_pkg
// Shared definitions for the configuration-write arbiter:
//   - state_e      : FSM state encoding (also exported on the debug state port)
//   - cfg_img_t    : 24-bit {CtrlReg1, CtrlReg2, CtrlReg3} image layout
//   - RST_CTRL_*   : control-register values loaded by reset
//   - field bit positions inside CtrlReg1 / CtrlReg3
//   - cfg_is_valid : legality check applied to a latched image
// ----------------------------------------------------------------------------
package cfg_write_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  localparam int CFG_W = 24;

  // Image order on the request bus: reg1 in [23:16], reg2 in [15:8], reg3 in [7:0].
  typedef struct packed {
    logic [7:0] reg1;
    logic [7:0] reg2;
    logic [7:0] reg3;
  } cfg_img_t;

  // Reset images: period 20, parity on, odd, little-endian, comparator 10/5.
  localparam logic [7:0] RST_CTRL_REG1 = 8'h60;
  localparam logic [7:0] RST_CTRL_REG2 = 8'h14;
  localparam logic [7:0] RST_CTRL_REG3 = 8'hA5;

  // CtrlReg1 fields.
  localparam int REG1_PERIOD_HI_MSB = 3;  // period[11:8]
  localparam int REG1_PERIOD_HI_LSB = 0;
  localparam int REG1_RSVD_BIT      = 4;  // must be written as 0

  // CtrlReg3 fields: upper comparator nibble must not be below the lower one.
  localparam int REG3_HI_MSB = 7;
  localparam int REG3_HI_LSB = 4;
  localparam int REG3_LO_MSB = 3;
  localparam int REG3_LO_LSB = 0;

  // Returns 1 when the image may be committed to the control-register block.
  function automatic logic cfg_is_valid(input cfg_img_t img,
                                        input logic [11:0] min_period);
    logic [11:0] period;
    logic        period_ok;
    logic        rsvd_ok;
    logic        comp_ok;
    period    = {img.reg1[REG1_PERIOD_HI_MSB:REG1_PERIOD_HI_LSB], img.reg2};
    period_ok = (period >= min_period);
    rsvd_ok   = (img.reg1[REG1_RSVD_BIT] == 1'b0);
    comp_ok   = (img.reg3[REG3_HI_MSB:REG3_HI_LSB] >= img.reg3[REG3_LO_MSB:REG3_LO_LSB]);
    return period_ok && rsvd_ok && comp_ok;
  endfunction

endpackage

// File: rtl/cfg_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// cfg_write_arbiter_if
// Bundles the two requester ports, the UART line-busy input, the
// control-register write port and the debug state of cfg_write_arbiter.
//
// Handshake: a requester raises *_req_i and holds it (level) together with a
// stable *_cfg_i until the arbiter returns a one-cycle *_ack_o; *_err_o is
// meaningful only in the cycle *_ack_o is high (1 = rejected or timed out).
// A request still high in the cycle after its ack is a new request. we_o is a
// one-cycle strobe; ctrl_reg*_o carry the new images in that same cycle and
// hold them until the next strobe.
//
// Signals (directions as seen by the arbiter, modport slave):
//   a_req_i/b_req_i     in   request level
//   a_cfg_i/b_cfg_i     in   24-bit {reg1, reg2, reg3} image
//   a_ack_o/b_ack_o     out  completion pulse
//   a_err_o/b_err_o     out  completion status
//   line_busy_i         in   UART frame in progress, no commit while high
//   we_o                out  control-register write strobe
//   ctrl_reg1..3_o      out  control-register images
//   cfg_pending_o       out  transaction in flight (state != IDLE)
//   state_o             out  FSM state for debug/checkers
// ----------------------------------------------------------------------------
interface cfg_write_arbiter_if;
  import cfg_write_arbiter_pkg::*;

  logic        a_req_i;
  logic [23:0] a_cfg_i;
  logic        a_ack_o;
  logic        a_err_o;
  logic        b_req_i;
  logic [23:0] b_cfg_i;
  logic        b_ack_o;
  logic        b_err_o;
  logic        line_busy_i;
  logic        we_o;
  logic [7:0]  ctrl_reg1_o;
  logic [7:0]  ctrl_reg2_o;
  logic [7:0]  ctrl_reg3_o;
  logic        cfg_pending_o;
  state_e      state_o;

  modport slave (
    input  a_req_i, a_cfg_i, b_req_i, b_cfg_i, line_busy_i,
    output a_ack_o, a_err_o, b_ack_o, b_err_o, we_o,
           ctrl_reg1_o, ctrl_reg2_o, ctrl_reg3_o, cfg_pending_o, state_o
  );

  modport master (
    output a_req_i, a_cfg_i, b_req_i, b_cfg_i, line_busy_i,
    input  a_ack_o, a_err_o, b_ack_o, b_err_o, we_o,
           ctrl_reg1_o, ctrl_reg2_o, ctrl_reg3_o, cfg_pending_o, state_o
  );

endinterface

// File: rtl/cfg_write_arbiter_rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant. Grant is combinational from req_i and the
// registered priority pointer; the pointer moves only when update_i is high,
// to favour the requester that was NOT granted in that cycle.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset (priority to req[0])
//   req_i[1:0]  request vector, bit 0 = A, bit 1 = B
//   update_i    advance the pointer past the current grant
//   grant_o[1:0] one-hot grant (or 0 when nothing is requested)
// ----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  logic prio_b_q;  // 1: requester B wins a tie

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = prio_b_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b_q <= 1'b0;
    end else if (update_i && (grant_o != 2'b00)) begin
      // A just served -> B next on a tie, and vice versa.
      prio_b_q <= grant_o[0];
    end
  end

endmodule

// File: rtl/cfg_write_arbiter.sv
// ----------------------------------------------------------------------------
// cfg_write_arbiter
// Serialises configuration writes from two requesters (A, B) into the UART
// control-register block. A granted image is latched into a shadow register,
// checked for legality, held until the UART line is idle, then written with a
// single we_o strobe. Each transaction ends with one ack (plus err) to the
// granted requester.
//
// Parameters:
//   TIMEOUT_CYCLES  max WAIT cycles with line busy before aborting (err=1)
//   MIN_PERIOD      smallest legal acquisition period {reg1[3:0], reg2}
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   cfg_write_arbiter_if.slave (requesters, line busy, register port,
//         pending flag, debug state)
//
// Timing with the line idle: IDLE(req seen) -> CHECK -> WAIT -> COMMIT(we_o)
// -> RESP(ack), i.e. we_o three cycles and ack four cycles after the IDLE
// cycle that sampled the request. Rejected images go CHECK -> RESP.
// ----------------------------------------------------------------------------
module cfg_write_arbiter
  import cfg_write_arbiter_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1023,
  parameter logic [11:0] MIN_PERIOD     = 12'd4
) (
  input  logic              clk,
  input  logic              rst,
  cfg_write_arbiter_if.slave bus
);

  state_e      state_q;
  cfg_img_t    shadow_q;
  logic        gnt_b_q;     // requester owning the current transaction
  logic [15:0] wait_cnt_q;
  logic [15:0] wait_cnt_d;
  logic        we_q;
  logic        a_ack_q, b_ack_q;
  logic        a_err_q, b_err_q;
  logic [7:0]  reg1_q, reg2_q, reg3_q;

  logic [1:0]  arb_req;
  logic [1:0]  arb_grant;
  logic        arb_update;

  // In IDLE the arbiter sees the live requests. Afterwards it sees only the
  // owner, so the pointer update in RESP is correct even if the owner has
  // already dropped its request.
  assign arb_req    = (state_q == ST_IDLE) ? {bus.b_req_i, bus.a_req_i}
                                           : (gnt_b_q ? 2'b10 : 2'b01);
  assign arb_update = (state_q == ST_RESP);

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    (arb_req),
    .update_i (arb_update),
    .grant_o  (arb_grant)
  );

  assign wait_cnt_d = wait_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      gnt_b_q    <= 1'b0;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      reg1_q     <= RST_CTRL_REG1;
      reg2_q     <= RST_CTRL_REG2;
      reg3_q     <= RST_CTRL_REG3;
    end else begin
      // Strobes are single-cycle by default.
      we_q    <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (arb_grant != 2'b00) begin
            gnt_b_q    <= arb_grant[1];
            shadow_q   <= arb_grant[1] ? cfg_img_t'(bus.b_cfg_i)
                                       : cfg_img_t'(bus.a_cfg_i);
            wait_cnt_q <= '0;
            state_q    <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (cfg_is_valid(shadow_q, MIN_PERIOD)) begin
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_RESP;
            a_ack_q <= ~gnt_b_q;
            b_ack_q <= gnt_b_q;
            a_err_q <= ~gnt_b_q;
            b_err_q <= gnt_b_q;
          end
        end

        ST_WAIT: begin
          if (!bus.line_busy_i) begin
            // Registers and strobe change together so the block sees the
            // new images in the we_o cycle.
            state_q <= ST_COMMIT;
            we_q    <= 1'b1;
            reg1_q  <= shadow_q.reg1;
            reg2_q  <= shadow_q.reg2;
            reg3_q  <= shadow_q.reg3;
          end else if (wait_cnt_d == TIMEOUT_CYCLES) begin
            // This was the TIMEOUT_CYCLES-th busy WAIT cycle: give up.
            state_q <= ST_RESP;
            a_ack_q <= ~gnt_b_q;
            b_ack_q <= gnt_b_q;
            a_err_q <= ~gnt_b_q;
            b_err_q <= gnt_b_q;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end

        ST_COMMIT: begin
          state_q <= ST_RESP;
          a_ack_q <= ~gnt_b_q;
          b_ack_q <= gnt_b_q;
        end

        ST_RESP: begin
          // ack is on the outputs this cycle; pointer advances via arb_update.
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.we_o          = we_q;
  assign bus.a_ack_o       = a_ack_q;
  assign bus.b_ack_o       = b_ack_q;
  assign bus.a_err_o       = a_err_q;
  assign bus.b_err_o       = b_err_q;
  assign bus.ctrl_reg1_o   = reg1_q;
  assign bus.ctrl_reg2_o   = reg2_q;
  assign bus.ctrl_reg3_o   = reg3_q;
  assign bus.cfg_pending_o = (state_q != ST_IDLE);
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
module tb_cfg_write_arbiter;
  import cfg_write_arbiter_pkg::*;

  localparam int ACK_W = 26;  // {is_b, err, regs[23:0]}
  localparam logic [23:0] RST_IMG = 24'h60_14_A5;

  // -------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cfg_write_arbiter_if bus();

  cfg_write_arbiter #(
    .TIMEOUT_CYCLES (16'd1023),
    .MIN_PERIOD     (12'd4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // -------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [ACK_W-1:0] exp_ack_q[$];
  logic [23:0]      exp_we_q[$];
  logic [23:0]      model_regs;
  int last_we_cyc  = -1;
  int ack_seen     = 0;
  int we_seen      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Push the response (and write, if the image is legal) a transaction must produce.
  task automatic expect_txn(input bit is_b, input logic [23:0] cfg, input bit ok);
    if (ok) begin
      model_regs = cfg;
      exp_we_q.push_back(cfg);
    end
    exp_ack_q.push_back({is_b, ~ok, model_regs});
  endtask

  // Monitor: compares every ack and every write strobe against the queues.
  always @(negedge clk) begin
    logic [ACK_W-1:0] e;
    logic [23:0]      w;
    logic [23:0]      regs;
    if (!rst) begin
      regs = {bus.ctrl_reg1_o, bus.ctrl_reg2_o, bus.ctrl_reg3_o};
      if (bus.a_ack_o || bus.b_ack_o) begin
        ack_seen++;
        check("one_ack", {31'b0, bus.a_ack_o & bus.b_ack_o}, 32'd0);
        if (exp_ack_q.size() == 0) begin
          fail_now("unexpected_ack");
        end else begin
          e = exp_ack_q.pop_front();
          check("ack_who",  {31'b0, bus.b_ack_o}, {31'b0, e[25]});
          check("ack_err",  {31'b0, bus.b_ack_o ? bus.b_err_o : bus.a_err_o}, {31'b0, e[24]});
          check("ack_regs", {8'b0, regs}, {8'b0, e[23:0]});
        end
      end
      if ((!bus.a_ack_o && bus.a_err_o) || (!bus.b_ack_o && bus.b_err_o))
        fail_now("err_without_ack");
      if (bus.we_o) begin
        we_seen++;
        last_we_cyc = cyc;
        check("we_in_commit", {29'b0, bus.state_o}, {29'b0, ST_COMMIT});
        if (exp_we_q.size() == 0) begin
          fail_now("unexpected_we");
        end else begin
          w = exp_we_q.pop_front();
          check("we_regs", {8'b0, regs}, {8'b0, w});
        end
      end
    end
  end

  // -------------------------------------------------------------- driver tasks
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.a_req_i = 1'b0;
    bus.b_req_i = 1'b0;
    bus.line_busy_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_regs = RST_IMG;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_regs"}, {8'b0, bus.ctrl_reg1_o, bus.ctrl_reg2_o, bus.ctrl_reg3_o}, {8'b0, RST_IMG});
    check({tag, "_we"}, {31'b0, bus.we_o}, 32'd0);
    check({tag, "_ack_err"}, {28'b0, bus.a_ack_o, bus.b_ack_o, bus.a_err_o, bus.b_err_o}, 32'd0);
    check({tag, "_pending"}, {31'b0, bus.cfg_pending_o}, 32'd0);
    check({tag, "_state"}, {29'b0, bus.state_o}, {29'b0, ST_IDLE});
  endtask

  task automatic start_req(input bit is_b, input logic [23:0] cfg, output int t0);
    @(negedge clk);
    if (is_b) begin
      bus.b_cfg_i = cfg;
      bus.b_req_i = 1'b1;
    end else begin
      bus.a_cfg_i = cfg;
      bus.a_req_i = 1'b1;
    end
    t0 = cyc;
  endtask

  // Waits (bounded) for the ack of one requester; optionally drops its request.
  task automatic wait_ack(input bit is_b, input int budget, input bit drop, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (is_b ? bus.b_ack_o : bus.a_ack_o) begin
        at = cyc;
        if (drop) begin
          if (is_b) bus.b_req_i = 1'b0;
          else      bus.a_req_i = 1'b0;
        end
        break;
      end
    end
    if (at < 0) begin
      fail_now(is_b ? "ack_timeout_b" : "ack_timeout_a");
      if (is_b) bus.b_req_i = 1'b0;
      else      bus.a_req_i = 1'b0;
    end
  endtask

  // -------------------------------------------------------------- stimulus
  logic [23:0] t4_cfg [6] = '{24'h10_28_A5, 24'h00_28_5A, 24'h00_04_55,
                              24'h0F_FF_F0, 24'h00_00_00, 24'h00_03_FF};
  bit          t4_ok  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int t0, at, at2, f, we_before, ack_before;
    bus.a_req_i = 1'b0;
    bus.b_req_i = 1'b0;
    bus.a_cfg_i = '0;
    bus.b_cfg_i = '0;
    bus.line_busy_i = 1'b0;
    model_regs = RST_IMG;

    // Reset state.
    apply_reset();
    check_reset_state("rst0");

    // Single A write, line idle: we_o at +3, ack at +4.
    expect_txn(1'b0, 24'h00_28_A5, 1'b1);
    start_req(1'b0, 24'h00_28_A5, t0);
    wait_ack(1'b0, 20, 1'b1, at);
    check("t1_we_lat",  last_we_cyc - t0, 32'd3);
    check("t1_ack_lat", at - t0, 32'd4);

    // Simultaneous A and B after reset: A first, then B.
    apply_reset();
    we_before = we_seen;
    expect_txn(1'b0, 24'h00_28_A5, 1'b1);
    expect_txn(1'b1, 24'h01_00_73, 1'b1);
    @(negedge clk);
    bus.a_cfg_i = 24'h00_28_A5;
    bus.b_cfg_i = 24'h01_00_73;
    bus.a_req_i = 1'b1;
    bus.b_req_i = 1'b1;
    t0 = cyc;
    wait_ack(1'b0, 20, 1'b1, at);
    wait_ack(1'b1, 20, 1'b1, at2);
    check("t2_a_ack_lat", at - t0, 32'd4);
    check("t2_b_ack_lat", at2 - t0, 32'd9);
    check("t2_we_count", we_seen - we_before, 32'd2);
    check("t2_final_regs", {8'b0, bus.ctrl_reg1_o, bus.ctrl_reg2_o, bus.ctrl_reg3_o}, 32'h0001_0073);

    // B with period 3: rejected, registers stay at reset images.
    apply_reset();
    we_before = we_seen;
    expect_txn(1'b1, 24'h00_03_A5, 1'b0);
    start_req(1'b1, 24'h00_03_A5, t0);
    wait_ack(1'b1, 20, 1'b1, at);
    check("t3_rej_lat", at - t0, 32'd2);
    check("t3_no_we", we_seen - we_before, 32'd0);

    // Legality boundaries: reserved bit, comparator order, period edges.
    for (int i = 0; i < 6; i++) begin
      expect_txn(1'b0, t4_cfg[i], t4_ok[i]);
      start_req(1'b0, t4_cfg[i], t0);
      wait_ack(1'b0, 20, 1'b1, at);
      check($sformatf("t4_lat_%0d", i), at - t0, t4_ok[i] ? 32'd4 : 32'd2);
    end

    // Request dropped right after grant still completes.
    expect_txn(1'b0, 24'h00_30_21, 1'b1);
    start_req(1'b0, 24'h00_30_21, t0);
    @(negedge clk);
    bus.a_req_i = 1'b0;
    wait_ack(1'b0, 20, 1'b0, at);
    check("t5_ack_lat", at - t0, 32'd4);

    // Request held past its ack is served again.
    expect_txn(1'b0, 24'h00_31_11, 1'b1);
    expect_txn(1'b0, 24'h00_32_22, 1'b1);
    start_req(1'b0, 24'h00_31_11, t0);
    wait_ack(1'b0, 20, 1'b0, at);
    bus.a_cfg_i = 24'h00_32_22;
    wait_ack(1'b0, 20, 1'b1, at2);
    check("t6_reissue_gap", at2 - at, 32'd5);

    // Line busy for 50 cycles: write one cycle after busy falls.
    bus.line_busy_i = 1'b1;
    expect_txn(1'b0, 24'h00_40_33, 1'b1);
    start_req(1'b0, 24'h00_40_33, t0);
    repeat (50) @(negedge clk);
    bus.line_busy_i = 1'b0;
    f = cyc;
    wait_ack(1'b0, 20, 1'b1, at);
    check("t7_we_after_busy", last_we_cyc - f, 32'd1);

    // Line stuck busy: abort after 1023 WAIT cycles, no write.
    we_before = we_seen;
    bus.line_busy_i = 1'b1;
    expect_txn(1'b0, 24'h00_44_44, 1'b0);
    start_req(1'b0, 24'h00_44_44, t0);
    wait_ack(1'b0, 1100, 1'b1, at);
    check("t8_timeout_lat", at - t0, 32'd1025);
    check("t8_no_we", we_seen - we_before, 32'd0);
    bus.line_busy_i = 1'b0;

    // Reset while in WAIT: no ack, no write, registers back to reset images.
    we_before  = we_seen;
    ack_before = ack_seen;
    bus.line_busy_i = 1'b1;
    start_req(1'b0, 24'h00_50_55, t0);
    repeat (10) @(negedge clk);
    check("t9_in_wait", {29'b0, bus.state_o}, {29'b0, ST_WAIT});
    rst = 1'b1;
    bus.a_req_i = 1'b0;
    bus.line_busy_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_regs = RST_IMG;
    check_reset_state("rst_wait");
    repeat (20) @(negedge clk);
    check("t9_no_ack", ack_seen - ack_before, 32'd0);
    check("t9_no_we", we_seen - we_before, 32'd0);

    // Every queued expectation consumed.
    check("ack_queue_empty", exp_ack_q.size(), 32'd0);
    check("we_queue_empty", exp_we_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
